tlc_sensor_conditioner: RTL and testbench

- Upstream front end for the two-street traffic light controller.
- Takes raw, noisy, asynchronous vehicle-loop detector inputs for street A and street B.
- Produces the clean, debounced, gap-tolerant occupancy signals Ta/Tb that the controller consumes.
- Also keeps per-street saturating arrival counts and emits one-cycle arrival pulses for statistics.

---
 rtl/tlc_sensor_conditioner.sv | 161 ++++++++++++++++
 tb/tb_tlc_sensor_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tlc_sensor_conditioner.sv
// Loop-detector front end: synchronizes, debounces and gap-bridges the street A/B
// sensors into Ta/Tb, and keeps saturating per-street arrival counts.
module tlc_sensor_conditioner #(
  parameter int DEBOUNCE = 3,
  parameter int HOLD     = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sa_raw,
  input  logic             sb_raw,
  input  logic             clr_counts,
  output logic             Ta,
  output logic             Tb,
  output logic             a_arrive,
  output logic             b_arrive,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  tlc_sensor_channel #(
    .DEBOUNCE (DEBOUNCE),
    .HOLD     (HOLD),
    .CNT_W    (CNT_W)
  ) u_chan_a (
    .clk        (clk),
    .reset      (reset),
    .raw        (sa_raw),
    .clr_counts (clr_counts),
    .occ        (Ta),
    .arrive     (a_arrive),
    .count      (a_count)
  );

  tlc_sensor_channel #(
    .DEBOUNCE (DEBOUNCE),
    .HOLD     (HOLD),
    .CNT_W    (CNT_W)
  ) u_chan_b (
    .clk        (clk),
    .reset      (reset),
    .raw        (sb_raw),
    .clr_counts (clr_counts),
    .occ        (Tb),
    .arrive     (b_arrive),
    .count      (b_count)
  );

endmodule

// One detector channel: two-flop synchronizer, qualify/linger FSM, arrival counter.
//   state  | meaning
//   IDLE   | no car, waiting for a synchronized high sample
//   QUAL   | counting consecutive high samples before declaring a car
//   OCC    | car present, sensor high
//   LINGER | sensor dropped, holding occupancy for up to HOLD more samples
module tlc_sensor_channel #(
  parameter int DEBOUNCE = 3,
  parameter int HOLD     = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             clr_counts,
  output logic             occ,
  output logic             arrive,
  output logic [CNT_W-1:0] count
);

  localparam int TMAX = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    DEB_LAST  = TW'(DEBOUNCE - 1);
  localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD);
  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, QUAL, OCC, LINGER} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          sync_1, s_sync;
  logic          arrive_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      sync_1 <= raw;
      s_sync <= sync_1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    arrive_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s_sync) begin
          state_nxt = QUAL;
          cnt_nxt   = TW'(1);
        end
      end
      QUAL: begin
        if (!s_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt  = OCC;
          arrive_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      OCC: begin
        if (!s_sync) begin
          state_nxt = LINGER;
          cnt_nxt   = TW'(1);
        end
      end
      LINGER: begin
        // A returning sensor is treated as the same car, so no new arrival.
        if (s_sync) begin
          state_nxt = OCC;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      occ    <= 1'b0;
      arrive <= 1'b0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      occ    <= (state_nxt == OCC) || (state_nxt == LINGER);
      arrive <= arrive_nxt;
      // Clear takes effect first, so a same-cycle arrival leaves a count of one.
      if (clr_counts) begin
        count <= arrive_nxt ? CNT_W'(1) : '0;
      end else if (arrive_nxt && (count != COUNT_MAX)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Bench for tlc_sensor_conditioner: directed scenarios then random sensor traffic,
// checked every cycle against a run-length occupancy model.
module tb_tlc_sensor_conditioner;

  localparam int DEBOUNCE = 3;
  localparam int HOLD     = 4;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sa_raw = 1'b0;
  logic             sb_raw = 1'b0;
  logic             clr_counts = 1'b0;
  logic             Ta, Tb, a_arrive, b_arrive;
  logic [CNT_W-1:0] a_count, b_count;

  int total = 0;
  int bad   = 0;

  // Reference model: sensor pipeline delay plus high/low run lengths per street.
  logic ra1, ra2, rb1, rb2;
  logic m_ta, m_tb, m_aa, m_ba;
  int   hi_a, lo_a, hi_b, lo_b, m_ca, m_cb;

  tlc_sensor_conditioner #(
    .DEBOUNCE (DEBOUNCE),
    .HOLD     (HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sa_raw     (sa_raw),
    .sb_raw     (sb_raw),
    .clr_counts (clr_counts),
    .Ta         (Ta),
    .Tb         (Tb),
    .a_arrive   (a_arrive),
    .b_arrive   (b_arrive),
    .a_count    (a_count),
    .b_count    (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ra1 = 0; ra2 = 0; rb1 = 0; rb2 = 0;
    m_ta = 0; m_tb = 0; m_aa = 0; m_ba = 0;
    hi_a = 0; lo_a = 0; hi_b = 0; lo_b = 0;
    m_ca = 0; m_cb = 0;
  endtask

  // A car is declared after DEBOUNCE consecutive high samples while vacant,
  // and released after HOLD+1 consecutive low samples while occupied.
  task automatic chan_step(input logic s, input logic clr, inout logic occ,
                           inout int hi, inout int lo, inout int cnt, output logic arr);
    if (s) begin hi++; lo = 0; end
    else   begin lo++; hi = 0; end
    arr = 1'b0;
    if (!occ && hi >= DEBOUNCE) begin
      occ = 1'b1;
      arr = 1'b1;
    end else if (occ && lo > HOLD) begin
      occ = 1'b0;
    end
    if (clr) cnt = arr ? 1 : 0;
    else if (arr && cnt < CNT_MAX) cnt++;
  endtask

  task automatic step(input logic a, input logic b, input logic clr);
    logic sa, sb;
    sa_raw = a;
    sb_raw = b;
    clr_counts = clr;
    if (reset) begin
      model_reset();
    end else begin
      sa = ra2; ra2 = ra1; ra1 = a;
      sb = rb2; rb2 = rb1; rb1 = b;
      chan_step(sa, clr, m_ta, hi_a, lo_a, m_ca, m_aa);
      chan_step(sb, clr, m_tb, hi_b, lo_b, m_cb, m_ba);
    end
    @(posedge clk);
    @(negedge clk);
    check("Ta", Ta, m_ta);
    check("Tb", Tb, m_tb);
    check("a_arrive", a_arrive, m_aa);
    check("b_arrive", b_arrive, m_ba);
    check("a_count", a_count, m_ca);
    check("b_count", b_count, m_cb);
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    logic seen;
    logic va, vb;
    int   la, lb;

    model_reset();
    @(negedge clk);

    // Reset held with sensors high: everything stays cleared.
    reset = 1'b1;
    step(1, 1, 0);
    step(1, 1, 0);
    check("rst_ta", Ta, 0);
    check("rst_count", a_count, 0);

    // Release with sensors held high: T rises after edge 4 (fifth edge after release).
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    check("rise_early_ta", Ta, 0);
    step(1, 1, 0);
    check("rise_ta", Ta, 1);
    check("rise_tb", Tb, 1);
    check("rise_a_arrive", a_arrive, 1);
    step(1, 1, 0);
    check("arrive_one_cycle", a_arrive, 0);
    check("rise_a_count", a_count, 1);
    check("rise_b_count", b_count, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0);

    // Two-cycle glitch must never raise Ta.
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin step(1, 0, 0); seen |= Ta | a_arrive; end
    for (int i = 0; i < 8; i++) begin step(0, 0, 0); seen |= Ta | a_arrive; end
    check("glitch_seen", seen, 0);
    check("glitch_count", a_count, 1);

    // Gap bridging: three low cycles are absorbed.
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); seen |= ~Ta; end
    for (int i = 0; i < 4; i++) begin step(1, 0, 0); seen |= ~Ta; end
    check("gap_dropped", seen, 0);
    check("gap_count", a_count, 2);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    check("fall_early_ta", Ta, 1);
    step(0, 0, 0);
    check("fall_ta", Ta, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Clear, then five separated B arrivals saturate the 2-bit counter.
    step(0, 0, 1);
    check("clr_a_count", a_count, 0);
    check("clr_b_count", b_count, 0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 6; i++) step(0, 1, 0);
      check("sat_b_count", b_count, sat_exp[k]);
      for (int i = 0; i < 10; i++) step(0, 0, 0);
    end

    // Clear coinciding with an arrival leaves a count of one.
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 1, 1);
    check("clr_arrive_pulse", b_arrive, 1);
    check("clr_arrive_count", b_count, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0);

    // Async reset while A lingers and B qualifies.
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check("pre_rst_ta", Ta, 1);
    check("pre_rst_a_count", a_count, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ta", Ta, 0);
    check("async_rst_tb", Tb, 0);
    check("async_rst_a_count", a_count, 0);
    check("async_rst_b_count", b_count, 0);
    @(negedge clk);
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(0, 0, 0);

    // Random bursty traffic on both streets with occasional clears.
    la = 0; lb = 0; va = 0; vb = 0;
    for (int i = 0; i < 3000; i++) begin
      if (la == 0) begin va = 1'($urandom_range(0, 1)); la = $urandom_range(1, 9); end
      if (lb == 0) begin vb = 1'($urandom_range(0, 1)); lb = $urandom_range(1, 9); end
      la--;
      lb--;
      step(va, vb, ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
